// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - op codes, FSM encoding and op-class helper for seq_alu
package seq_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;
    localparam logic [3:0] ALU_MULU = 4'hC;
    localparam logic [3:0] ALU_MUL  = 4'hD;
    localparam logic [3:0] ALU_DIVU = 4'hE;
    localparam logic [3:0] ALU_DIV  = 4'hF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Codes C..F go to the iterative engine; bit 1 selects divide, bit 0 selects signed.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result bundle between the EX-stage controller and seq_alu
interface seq_alu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             ovf;
    logic             carry;

    modport master (
        output in_valid, aluc, a, b, kill,
        input  in_ready, out_valid, r, hi, z, ovf, carry
    );

    modport slave (
        input  in_valid, aluc, a, b, kill,
        output in_ready, out_valid, r, hi, z, ovf, carry
    );
endinterface

// File: rtl/seq_muldiv_core.sv
// rtl/seq_muldiv_core.sv - iterative shift-add multiplier / restoring divider with sign fix-up
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CNT_W = $clog2(WIDTH);

    logic               busy_q, div_q, neg_lo, neg_hi, sa, sb;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     p, step_p, mul_sum, sh_r;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   q, m, step_q, ma, mb;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        sa = is_signed & a[WIDTH-1];
        sb = is_signed & b[WIDTH-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        // p holds the running high half (mul) or partial remainder (div); q the low half / quotient
        mul_sum = q[0] ? p + {1'b0, m} : p;
        sh_r    = {p[WIDTH-1:0], q[WIDTH-1]};
        trial   = {1'b0, sh_r} - {2'b00, m};
        if (div_q) begin
            if (!trial[WIDTH+1]) begin
                step_p = trial[WIDTH:0];
                step_q = {q[WIDTH-2:0], 1'b1};
            end else begin
                step_p = sh_r;
                step_q = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_p = {1'b0, mul_sum[WIDTH:1]};
            step_q = {mul_sum[0], q[WIDTH-1:1]};
        end
        prod_neg = -{step_p[WIDTH-1:0], step_q};
        if (div_q) begin
            lo = neg_lo ? -step_q : step_q;
            hi = neg_hi ? -step_p[WIDTH-1:0] : step_p[WIDTH-1:0];
        end else begin
            lo = neg_lo ? prod_neg[WIDTH-1:0] : step_q;
            hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : step_p[WIDTH-1:0];
        end
    end

    assign busy = busy_q;
    assign done = busy_q & (cnt == '0) & ~kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            cnt    <= '0;
            p      <= '0;
            q      <= '0;
            m      <= '0;
        end else if (busy_q) begin
            if (kill) begin
                busy_q <= 1'b0;
            end else begin
                p <= step_p;
                q <= step_q;
                if (cnt == '0) busy_q <= 1'b0;
                else           cnt    <= cnt - 1'b1;
            end
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            cnt    <= CNT_W'(WIDTH - 1);
            p      <= '0;
            q      <= ma;
            m      <= mb;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle datapath, handshake FSM and result registers
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);
    logic [0:0]         state;
    logic               accept, is_md, div0, start, core_busy, core_done;
    logic [WIDTH-1:0]   core_lo, core_hi, alu_r, r_q, hi_q;
    logic               alu_ovf, alu_carry, ovf_q, carry_q, out_valid_q;
    logic [WIDTH:0]     add_full, sub_full;
    logic [SHAMT_W-1:0] shamt;

    assign accept = bus.in_valid & (state == ST_IDLE);
    assign is_md  = is_muldiv(bus.aluc);
    assign div0   = bus.aluc[1] & (bus.b == '0);
    assign start  = accept & is_md & ~div0;
    assign shamt  = bus.b[SHAMT_W-1:0];

    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_r     = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (bus.aluc)
            ALU_ADD: begin
                alu_r     = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_r     = sub_full[WIDTH-1:0];
                alu_carry = sub_full[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND:  alu_r = bus.a & bus.b;
            ALU_OR:   alu_r = bus.a | bus.b;
            ALU_XOR:  alu_r = bus.a ^ bus.b;
            ALU_NOR:  alu_r = ~(bus.a | bus.b);
            ALU_SLT:  alu_r = WIDTH'($signed(bus.a) < $signed(bus.b));
            ALU_SLTU: alu_r = WIDTH'(bus.a < bus.b);
            ALU_SLL:  alu_r = bus.a << shamt;
            ALU_SRL:  alu_r = bus.a >> shamt;
            ALU_SRA:  alu_r = WIDTH'($signed(bus.a) >>> shamt);
            ALU_LUI:  alu_r = bus.b << (WIDTH / 2);
            default:  alu_r = '0;
        endcase
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_div    (bus.aluc[1]),
        .is_signed (bus.aluc[0]),
        .a         (bus.a),
        .b         (bus.b),
        .kill      (bus.kill),
        .busy      (core_busy),
        .done      (core_done),
        .lo        (core_lo),
        .hi        (core_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            hi_q        <= '0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && !is_md) begin
                r_q         <= alu_r;
                hi_q        <= '0;
                ovf_q       <= alu_ovf;
                carry_q     <= alu_carry;
                out_valid_q <= 1'b1;
            end else if (accept && div0) begin
                r_q         <= '1;
                hi_q        <= bus.a;
                ovf_q       <= 1'b0;
                carry_q     <= 1'b0;
                out_valid_q <= 1'b1;
            end else if (core_done) begin
                r_q         <= core_lo;
                hi_q        <= core_hi;
                ovf_q       <= 1'b0;
                carry_q     <= 1'b0;
                out_valid_q <= 1'b1;
            end
            // A kill leaves the result registers untouched; only the FSM unwinds.
            if (state == ST_IDLE) begin
                if (start) state <= ST_BUSY;
            end else if (bus.kill || core_done || !core_busy) begin
                state <= ST_IDLE;
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.hi        = hi_q;
    assign bus.z         = (r_q == '0);
    assign bus.ovf       = ovf_q;
    assign bus.carry     = carry_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) if32();
    seq_alu_if #(.WIDTH(8))  if8();

    seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    int errors = 0;
    int checks = 0;

    function automatic void model(input int w, input logic [3:0] op, input logic [31:0] ai, bi,
                                  output logic [31:0] r, hi, output logic ovf, carry, output int lat);
        longint mask, ua, ub, sa, sb, minv, maxv, res, h;
        int sh;
        mask = (longint'(1) << w) - 1;
        ua = {32'b0, ai} & mask;
        ub = {32'b0, bi} & mask;
        sa = ua[w-1] ? ua - (mask + 1) : ua;
        sb = ub[w-1] ? ub - (mask + 1) : ub;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        sh = int'(ub % w);
        res = 0; h = 0; ovf = 0; carry = 0; lat = 1;
        case (op)
            4'd0: begin res = ua + ub; carry = res[w]; ovf = (sa + sb > maxv) || (sa + sb < minv); end
            4'd1: begin res = ua - ub; carry = (ua >= ub); ovf = (sa - sb > maxv) || (sa - sb < minv); end
            4'd2: res = ua & ub;
            4'd3: res = ua | ub;
            4'd4: res = ua ^ ub;
            4'd5: res = ~(ua | ub);
            4'd6: res = (sa < sb) ? 1 : 0;
            4'd7: res = (ua < ub) ? 1 : 0;
            4'd8: res = ua << sh;
            4'd9: res = ua >> sh;
            4'd10: res = sa >>> sh;
            4'd11: res = ub << (w / 2);
            4'd12: begin res = ua * ub; h = res >> w; lat = w + 1; end
            4'd13: begin res = sa * sb; h = res >> w; lat = w + 1; end
            4'd14: if (ub == 0) begin res = mask; h = ua; end
                   else begin res = ua / ub; h = ua % ub; lat = w + 1; end
            default: if (sb == 0) begin res = mask; h = ua; end
                   else begin res = sa / sb; h = sa % sb; lat = w + 1; end
        endcase
        r  = 32'(res & mask);
        hi = 32'(h & mask);
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [3:0] op, input logic [31:0] a, b);
        if (w8) begin
            if8.in_valid = v; if8.aluc = op; if8.a = a[7:0]; if8.b = b[7:0];
        end else begin
            if32.in_valid = v; if32.aluc = op; if32.a = a; if32.b = b;
        end
    endtask

    task automatic sample(input bit w8, output logic ov, rdy, output logic [31:0] r, hi,
                          output logic z, ovf, carry);
        if (w8) begin
            ov = if8.out_valid; rdy = if8.in_ready; r = {24'b0, if8.r}; hi = {24'b0, if8.hi};
            z = if8.z; ovf = if8.ovf; carry = if8.carry;
        end else begin
            ov = if32.out_valid; rdy = if32.in_ready; r = if32.r; hi = if32.hi;
            z = if32.z; ovf = if32.ovf; carry = if32.carry;
        end
    endtask

    task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, b,
                         output logic [31:0] r, hi, output logic z, ovf, carry, output int lat);
        logic ov, rdy;
        @(negedge clk);
        drive(w8, 1'b1, op, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(w8, 1'b0, op, a, b);
        lat = 1;
        sample(w8, ov, rdy, r, hi, z, ovf, carry);
        while (!ov && lat < 200) begin
            @(negedge clk);
            lat++;
            sample(w8, ov, rdy, r, hi, z, ovf, carry);
        end
    endtask

    task automatic test_reset;
        logic ov, rdy, z, ovf, carry;
        logic [31:0] r, hi;
        for (int w = 0; w < 2; w++) begin
            sample(w[0], ov, rdy, r, hi, z, ovf, carry);
            checks++;
            if ({rdy, ov, r, hi, z, ovf, carry} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_w8=%0d: rdy=%b ov=%b r=%h hi=%h z=%b ovf=%b c=%b want rdy=1 ov=0 r=0 hi=0 z=1 ovf=0 c=0",
                         w, rdy, ov, r, hi, z, ovf, carry);
            end
        end
    endtask

    task automatic test_add_sub;
        logic [31:0] r, hi;
        logic z, ovf, carry;
        int lat;
        issue(0, 4'h0, 32'h7FFFFFFF, 32'h1, r, hi, z, ovf, carry, lat);
        checks++;
        if ({r, ovf, carry, z} !== {32'h80000000, 1'b1, 1'b0, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL add_ovf: r=%h ovf=%b c=%b z=%b lat=%0d want r=80000000 ovf=1 c=0 z=0 lat=1", r, ovf, carry, z, lat);
        end
        issue(0, 4'h1, 32'd5, 32'd5, r, hi, z, ovf, carry, lat);
        checks++;
        if ({r, z, carry, ovf} !== {32'h0, 1'b1, 1'b1, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL sub_zero: r=%h z=%b c=%b ovf=%b lat=%0d want r=0 z=1 c=1 ovf=0 lat=1", r, z, carry, ovf, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops [3];
        logic [31:0] av [3], bv [3], ex [3];
        logic ov, rdy, z, ovf, carry;
        logic [31:0] r, hi;
        ops = '{4'h2, 4'h3, 4'h6};
        av[0] = $urandom; bv[0] = $urandom; ex[0] = av[0] & bv[0];
        av[1] = $urandom; bv[1] = $urandom; ex[1] = av[1] | bv[1];
        av[2] = 32'hFFFFFFFF; bv[2] = 32'h1; ex[2] = 32'h1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, ops[i], av[i], bv[i]);
            @(negedge clk);
            sample(0, ov, rdy, r, hi, z, ovf, carry);
            checks++;
            if (ov !== 1'b1 || rdy !== 1'b1 || r !== ex[i] || hi !== 32'h0) begin
                errors++;
                $display("FAIL b2b_%0d: ov=%b rdy=%b r=%h hi=%h want ov=1 rdy=1 r=%h hi=0", i, ov, rdy, r, hi, ex[i]);
            end
        end
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        sample(0, ov, rdy, r, hi, z, ovf, carry);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ov=%b want 0", ov);
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  op [5];
        logic [31:0] av [5], bv [5], er [5], eh [5];
        int el [5];
        logic [31:0] r, hi;
        logic z, ovf, carry;
        int lat;
        op = '{4'hD, 4'hC, 4'hF, 4'hE, 4'hF};
        av = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        bv = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
        er = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
        eh = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd100, 32'h0};
        el = '{33, 33, 33, 1, 33};
        for (int i = 0; i < 5; i++) begin
            issue(0, op[i], av[i], bv[i], r, hi, z, ovf, carry, lat);
            checks++;
            if (r !== er[i] || hi !== eh[i] || ovf !== 1'b0 || carry !== 1'b0 || lat != el[i]) begin
                errors++;
                $display("FAIL muldiv_%0d: r=%h hi=%h ovf=%b c=%b lat=%0d want r=%h hi=%h ovf=0 c=0 lat=%0d",
                         i, r, hi, ovf, carry, lat, er[i], eh[i], el[i]);
            end
        end
    endtask

    task automatic test_kill;
        logic [31:0] r, hi;
        logic z, ovf, carry, ov, rdy, seen_ov, seen_rdy;
        int lat;
        issue(0, 4'h0, 32'd3, 32'd4, r, hi, z, ovf, carry, lat);
        checks++;
        if (r !== 32'd7 || lat != 1) begin
            errors++;
            $display("FAIL kill_pre: r=%h lat=%0d want r=7 lat=1", r, lat);
        end
        @(negedge clk);
        drive(0, 1'b1, 4'hE, $urandom, 32'd3);
        @(posedge clk);
        seen_ov = 0; seen_rdy = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
            sample(0, ov, rdy, r, hi, z, ovf, carry);
            seen_ov |= ov;
            seen_rdy |= rdy;
            if (k == 10) if32.kill = 1'b1;
        end
        checks++;
        if (seen_ov !== 1'b0 || seen_rdy !== 1'b0) begin
            errors++;
            $display("FAIL kill_busy: saw ov=%b rdy=%b while busy want 0 0", seen_ov, seen_rdy);
        end
        @(negedge clk);
        if32.kill = 1'b0;
        sample(0, ov, rdy, r, hi, z, ovf, carry);
        checks++;
        if (rdy !== 1'b1 || ov !== 1'b0 || r !== 32'd7 || hi !== 32'h0) begin
            errors++;
            $display("FAIL kill_after: rdy=%b ov=%b r=%h hi=%h want rdy=1 ov=0 r=7 hi=0", rdy, ov, r, hi);
        end
        issue(0, 4'h0, 32'd10, 32'd20, r, hi, z, ovf, carry, lat);
        checks++;
        if (r !== 32'd30 || lat != 1) begin
            errors++;
            $display("FAIL kill_next_add: r=%h lat=%0d want r=1e lat=1", r, lat);
        end
        if32.kill = 1'b1;
        issue(0, 4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, r, hi, z, ovf, carry, lat);
        if32.kill = 1'b0;
        checks++;
        if (r !== 32'hFF00FF00 || lat != 1) begin
            errors++;
            $display("FAIL kill_idle: r=%h lat=%0d want r=ff00ff00 lat=1", r, lat);
        end
    endtask

    task automatic test_rst_mid;
        logic [31:0] r, hi;
        logic z, ovf, carry, ov, rdy, seen_ov;
        issue(0, 4'h0, 32'h80000000, 32'h80000000, r, hi, z, ovf, carry, rdy);
        @(negedge clk);
        drive(0, 1'b1, 4'hD, 32'h12345, 32'h6789);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        rst = 1'b1;
        #1;
        sample(0, ov, rdy, r, hi, z, ovf, carry);
        checks++;
        if ({rdy, ov, r, hi, z, ovf, carry} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: rdy=%b ov=%b r=%h hi=%h z=%b ovf=%b c=%b want reset values", rdy, ov, r, hi, z, ovf, carry);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            sample(0, ov, rdy, r, hi, z, ovf, carry);
            seen_ov |= ov;
        end
        checks++;
        if (seen_ov !== 1'b0 || r !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_after: ov=%b r=%h want ov=0 r=0", seen_ov, r);
        end
    endtask

    task automatic test_random(input bit w8, input int n);
        logic [31:0] r, hi, er, eh, a, b;
        logic z, ovf, carry, eovf, ecarry;
        logic [3:0] op;
        int lat, elat, w;
        w = w8 ? 8 : 32;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 3);
                1: begin a = 32'h1 << (w - 1); b = '1; end
                2: a = $urandom_range(0, 9);
                default: ;
            endcase
            if (w8) begin a = a & 32'hFF; b = b & 32'hFF; end
            model(w, op, a, b, er, eh, eovf, ecarry, elat);
            issue(w8, op, a, b, r, hi, z, ovf, carry, lat);
            checks++;
            if ({r, hi, z, ovf, carry} !== {er, eh, (er == 32'h0), eovf, ecarry} || lat != elat) begin
                errors++;
                $display("FAIL rand_w%0d op=%h a=%h b=%h: r=%h hi=%h z=%b ovf=%b c=%b lat=%0d want r=%h hi=%h z=%b ovf=%b c=%b lat=%0d",
                         w, op, a, b, r, hi, z, ovf, carry, lat, er, eh, (er == 32'h0), eovf, ecarry, elat);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if32.kill = 1'b0;
        if8.kill  = 1'b0;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_add_sub;
        test_back_to_back;
        test_muldiv;
        test_kill;
        test_rst_mid;
        test_random(0, 150);
        test_random(1, 150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
